// File: rtl/acondicionador_entradas_if.sv
// Raw key/switch inputs and conditioned command outputs of the 2048 input stage.
// The master side is the board/consumer; the slave side is the conditioner.
interface acondicionador_entradas_if;
  logic [3:0] keys_n;
  logic       sw_start;
  logic       sw_fin;
  logic       btn_izq;
  logic       btn_der;
  logic       btn_up;
  logic       btn_down;
  logic       start;
  logic       fin;

  modport master (
    output keys_n, sw_start, sw_fin,
    input  btn_izq, btn_der, btn_up, btn_down,
    input  start, fin
  );

  modport slave (
    input  keys_n, sw_start, sw_fin,
    output btn_izq, btn_der, btn_up, btn_down,
    output start, fin
  );
endinterface

// File: rtl/acondicionador_entradas.sv
// Sync + debounce of keys/switches, one command pulse per direction press.
// Optional auto-repeat of a held direction: define INPUT_AUTOREPEAT_EN.
module acondicionador_entradas #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input logic clk,
  input logic rst,
  acondicionador_entradas_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0] SYNC_RST = 6'b00_1111;

  typedef enum logic {ARMED, HELD} st_t;

  logic [5:0]    s1;
  logic [5:0]    s2;
  logic [5:0]    act;
  logic [5:0]    stb;
  logic [5:0]    lvl;
  logic [CW-1:0] cnt [6];
  logic [3:0]    dir_q;
  logic [3:0]    newp;
  logic [3:0]    pulse;
  logic          start_q;
  logic          fin_q;
  st_t           st;

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt;
  logic [3:0]    orig;
  logic          rep_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= SYNC_RST;
      s2 <= SYNC_RST;
    end else begin
      s1 <= {io.sw_fin, io.sw_start, io.keys_n};
      s2 <= s1;
    end
  end

  // active-high view: [3:0] directions, [4] start, [5] fin
  assign act = {s2[5:4], ~s2[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      stb <= '0;
      lvl <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (act[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          stb[i] <= act[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      lvl <= stb;
    end
  end

  assign newp = lvl[3:0] & ~dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ARMED;
      dir_q   <= '0;
      pulse   <= '0;
      start_q <= 1'b0;
      fin_q   <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
      rcnt    <= '0;
      orig    <= '0;
      rep_ok  <= 1'b0;
`endif
    end else begin
      dir_q   <= lvl[3:0];
      start_q <= lvl[4];
      fin_q   <= lvl[5];
      pulse   <= '0;
      unique case (st)
        ARMED: begin
          if (newp != '0) begin
            st <= HELD;
            // a press joining one already held, or a tie, is dropped
            if ($onehot(newp) && (lvl[3:0] & dir_q) == '0) begin
              pulse <= newp;
            end
`ifdef INPUT_AUTOREPEAT_EN
            rcnt   <= '0;
            orig   <= newp;
            rep_ok <= $onehot(newp) && (lvl[3:0] & dir_q) == '0;
`endif
          end
        end
        HELD: begin
          if (lvl[3:0] == '0) begin
            st <= ARMED;
          end
`ifdef INPUT_AUTOREPEAT_EN
          else if (rep_ok && lvl[3:0] == orig) begin
            if (rcnt == RMAX) begin
              pulse <= orig;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end else begin
            rep_ok <= 1'b0;
            rcnt   <= '0;
          end
`else
          else begin
            st <= HELD;
          end
`endif
        end
        default: st <= ARMED;
      endcase
    end
  end

  assign io.btn_izq  = pulse[0];
  assign io.btn_der  = pulse[1];
  assign io.btn_up   = pulse[2];
  assign io.btn_down = pulse[3];
  assign io.start    = start_q;
  assign io.fin      = fin_q;
endmodule
